// File: rtl/arp_engine.sv
// ARP responder/resolver between the Ethernet RX demux and TX arbiter.
// Learns sender IP->MAC pairs, answers requests for the local IP and resolves lookups.
module arp_engine #(
  parameter logic [23:0] MAC_MSB     = 24'h010203,
  parameter logic [23:0] MAC_LSB     = 24'h040506,
  parameter logic [15:0] IP_MSB      = 16'hc0a8,
  parameter logic [15:0] IP_LSB      = 16'h0602,
  parameter int unsigned DEBUG       = 1,
  parameter int unsigned CACHE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        eth_req,
  input  logic        eth_ack,
  output logic [47:0] eth_dst_mac,
  output logic [47:0] eth_src_mac,
  output logic [15:0] eth_ethertype,
  output logic [7:0]  eth_axis_tdata,
  output logic        eth_axis_tlast,
  output logic        eth_axis_tvalid,
  input  logic        eth_axis_tready,
  input  logic        arp_lookup_req,
  input  logic [31:0] arp_lookup_ip,
  output logic        arp_lookup_done,
  output logic        arp_lookup_valid,
  output logic [47:0] arp_lookup_mac
);

  localparam int unsigned PtrW     = $clog2(CACHE_DEPTH);
  localparam logic [47:0] LocalMac = {MAC_MSB, MAC_LSB};
  localparam logic [31:0] LocalIp  = {IP_MSB, IP_LSB};

  typedef enum logic [1:0] {RxInit, RxIdle, RxEval, RxWait} rx_st_e;
  typedef enum logic [1:0] {TxIdle, TxReq, TxData} tx_st_e;

  rx_st_e rx_st_q, rx_st_d;
  tx_st_e tx_st_q, tx_st_d;

  logic [4:0]   rx_cnt_q, rx_cnt_d;
  logic [223:0] rx_sh_q, rx_sh_d;

  logic [CACHE_DEPTH-1:0]       cache_vld_q, cache_vld_d;
  logic [CACHE_DEPTH-1:0][31:0] cache_ip_q, cache_ip_d;
  logic [CACHE_DEPTH-1:0][47:0] cache_mac_q, cache_mac_d;
  logic [PtrW-1:0]              ptr_q, ptr_d;

  logic        rep_pend_q, rep_pend_d, req_pend_q, req_pend_d;
  logic [47:0] rep_sha_q, rep_sha_d;
  logic [31:0] rep_spa_q, rep_spa_d, req_ip_q, req_ip_d;
  logic        lk_done_q, lk_done_d, lk_valid_q, lk_valid_d;
  logic [47:0] lk_mac_q, lk_mac_d;

  logic [4:0]  tx_cnt_q, tx_cnt_d;
  logic [47:0] tx_dst_q, tx_dst_d, tx_tha_q, tx_tha_d;
  logic [31:0] tx_tpa_q, tx_tpa_d;
  logic        tx_reply_q, tx_reply_d;

  logic unused_debug, unused_rx_tha;
  assign unused_debug  = (DEBUG != 0);
  assign unused_rx_tha = ^rx_sh_q[79:32];

  // Frame fields once the shift register holds the first 28 bytes.
  logic [15:0] f_htype, f_ptype, f_oper;
  logic [7:0]  f_hlen, f_plen;
  logic [47:0] f_sha;
  logic [31:0] f_spa, f_tpa;
  assign f_htype = rx_sh_q[223:208];
  assign f_ptype = rx_sh_q[207:192];
  assign f_hlen  = rx_sh_q[191:184];
  assign f_plen  = rx_sh_q[183:176];
  assign f_oper  = rx_sh_q[175:160];
  assign f_sha   = rx_sh_q[159:112];
  assign f_spa   = rx_sh_q[111:80];
  assign f_tpa   = rx_sh_q[31:0];

  logic frame_ok, do_learn, do_reply, reply_done;
  assign frame_ok = (rx_cnt_q == 5'd28) && (f_htype == 16'h0001) && (f_ptype == 16'h0800) &&
                    (f_hlen == 8'd6) && (f_plen == 8'd4) &&
                    ((f_oper == 16'd1) || (f_oper == 16'd2));
  assign do_learn = (rx_st_q == RxEval) && frame_ok && (f_spa != 32'h0);
  assign do_reply = (rx_st_q == RxEval) && frame_ok && (f_oper == 16'd1) && (f_tpa == LocalIp);

  always_comb begin
    rx_st_d       = rx_st_q;
    rx_cnt_d      = rx_cnt_q;
    rx_sh_d       = rx_sh_q;
    s_axis_tready = (rx_st_q == RxIdle);
    unique case (rx_st_q)
      RxInit: rx_st_d = RxIdle;
      RxIdle: begin
        if (s_axis_tvalid) begin
          // Padding past byte 28 is consumed without disturbing the captured fields.
          if (rx_cnt_q < 5'd28) begin
            rx_sh_d  = {rx_sh_q[215:0], s_axis_tdata};
            rx_cnt_d = rx_cnt_q + 5'd1;
          end
          if (s_axis_tlast) rx_st_d = RxEval;
        end
      end
      RxEval: begin
        rx_cnt_d = '0;
        rx_st_d  = do_reply ? RxWait : RxIdle;
      end
      RxWait:  if (reply_done) rx_st_d = RxIdle;
      default: rx_st_d = RxIdle;
    endcase
  end

  logic            lk_hit, ln_hit;
  logic [PtrW-1:0] lk_idx, ln_idx;
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    ln_hit = 1'b0;
    ln_idx = '0;
    for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
      if (cache_vld_q[i] && (cache_ip_q[i] == arp_lookup_ip)) begin
        lk_hit = 1'b1;
        lk_idx = PtrW'(i);
      end
      if (cache_vld_q[i] && (cache_ip_q[i] == f_spa)) begin
        ln_hit = 1'b1;
        ln_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_ip_d  = cache_ip_q;
    cache_mac_d = cache_mac_q;
    ptr_d       = ptr_q;
    if (do_learn) begin
      if (ln_hit) begin
        cache_mac_d[ln_idx] = f_sha;
      end else begin
        cache_vld_d[ptr_q] = 1'b1;
        cache_ip_d[ptr_q]  = f_spa;
        cache_mac_d[ptr_q] = f_sha;
        ptr_d = (ptr_q == PtrW'(CACHE_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
    lk_done_d  = arp_lookup_req;
    lk_valid_d = arp_lookup_req && lk_hit;
    lk_mac_d   = arp_lookup_req ? (lk_hit ? cache_mac_q[lk_idx] : '0) : lk_mac_q;
  end

  assign arp_lookup_done  = lk_done_q;
  assign arp_lookup_valid = lk_valid_q;
  assign arp_lookup_mac   = lk_mac_q;

  logic [223:0] tx_frame, tx_frame_sh;
  assign tx_frame    = {16'h0001, 16'h0800, 8'h06, 8'h04, (tx_reply_q ? 16'h0002 : 16'h0001),
                        LocalMac, LocalIp, tx_tha_q, tx_tpa_q};
  assign tx_frame_sh = tx_frame << {tx_cnt_q, 3'b000};

  always_comb begin
    tx_st_d         = tx_st_q;
    tx_cnt_d        = tx_cnt_q;
    tx_dst_d        = tx_dst_q;
    tx_tha_d        = tx_tha_q;
    tx_tpa_d        = tx_tpa_q;
    tx_reply_d      = tx_reply_q;
    rep_pend_d      = rep_pend_q;
    rep_sha_d       = rep_sha_q;
    rep_spa_d       = rep_spa_q;
    req_pend_d      = req_pend_q;
    req_ip_d        = req_ip_q;
    reply_done      = 1'b0;
    eth_req         = 1'b0;
    eth_dst_mac     = '0;
    eth_src_mac     = '0;
    eth_ethertype   = '0;
    eth_axis_tdata  = '0;
    eth_axis_tlast  = 1'b0;
    eth_axis_tvalid = 1'b0;
    unique case (tx_st_q)
      TxIdle: begin
        if (rep_pend_q) begin
          tx_st_d    = TxReq;
          tx_reply_d = 1'b1;
          tx_dst_d   = rep_sha_q;
          tx_tha_d   = rep_sha_q;
          tx_tpa_d   = rep_spa_q;
          rep_pend_d = 1'b0;
        end else if (req_pend_q) begin
          tx_st_d    = TxReq;
          tx_reply_d = 1'b0;
          tx_dst_d   = '1;
          tx_tha_d   = '0;
          tx_tpa_d   = req_ip_q;
          req_pend_d = 1'b0;
        end
      end
      TxReq: begin
        eth_req       = 1'b1;
        eth_dst_mac   = tx_dst_q;
        eth_src_mac   = LocalMac;
        eth_ethertype = 16'h0806;
        if (eth_ack) begin
          tx_st_d  = TxData;
          tx_cnt_d = '0;
        end
      end
      TxData: begin
        eth_dst_mac     = tx_dst_q;
        eth_src_mac     = LocalMac;
        eth_ethertype   = 16'h0806;
        eth_axis_tvalid = 1'b1;
        eth_axis_tdata  = tx_frame_sh[223:216];
        eth_axis_tlast  = (tx_cnt_q == 5'd27);
        if (eth_axis_tready) begin
          if (tx_cnt_q == 5'd27) begin
            tx_st_d    = TxIdle;
            reply_done = tx_reply_q;
          end else begin
            tx_cnt_d = tx_cnt_q + 5'd1;
          end
        end
      end
      default: tx_st_d = TxIdle;
    endcase
    if (do_reply) begin
      rep_pend_d = 1'b1;
      rep_sha_d  = f_sha;
      rep_spa_d  = f_spa;
    end
    // A fresh miss replaces any request that has not yet been picked up.
    if (arp_lookup_req && !lk_hit) begin
      req_pend_d = 1'b1;
      req_ip_d   = arp_lookup_ip;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_st_q     <= RxInit;
      rx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      cache_vld_q <= '0;
      cache_ip_q  <= '0;
      cache_mac_q <= '0;
      ptr_q       <= '0;
      rep_pend_q  <= 1'b0;
      rep_sha_q   <= '0;
      rep_spa_q   <= '0;
      req_pend_q  <= 1'b0;
      req_ip_q    <= '0;
      lk_done_q   <= 1'b0;
      lk_valid_q  <= 1'b0;
      lk_mac_q    <= '0;
      tx_st_q     <= TxIdle;
      tx_cnt_q    <= '0;
      tx_dst_q    <= '0;
      tx_tha_q    <= '0;
      tx_tpa_q    <= '0;
      tx_reply_q  <= 1'b0;
    end else begin
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_sh_q     <= rx_sh_d;
      cache_vld_q <= cache_vld_d;
      cache_ip_q  <= cache_ip_d;
      cache_mac_q <= cache_mac_d;
      ptr_q       <= ptr_d;
      rep_pend_q  <= rep_pend_d;
      rep_sha_q   <= rep_sha_d;
      rep_spa_q   <= rep_spa_d;
      req_pend_q  <= req_pend_d;
      req_ip_q    <= req_ip_d;
      lk_done_q   <= lk_done_d;
      lk_valid_q  <= lk_valid_d;
      lk_mac_q    <= lk_mac_d;
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_dst_q    <= tx_dst_d;
      tx_tha_q    <= tx_tha_d;
      tx_tpa_q    <= tx_tpa_d;
      tx_reply_q  <= tx_reply_d;
    end
  end

endmodule

// File: tb/tb_arp_engine.sv
// Directed bench for arp_engine: expected TX frames are queued when stimulus is
// driven and compared byte by byte as the engine emits them.
module tb_arp_engine;

  localparam logic [47:0] LMac = 48'h010203040506;
  localparam logic [31:0] LIp  = 32'hc0a80602;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
  logic        eth_req, eth_ack = 1'b0;
  logic [47:0] eth_dst_mac, eth_src_mac;
  logic [15:0] eth_ethertype;
  logic [7:0]  eth_axis_tdata;
  logic        eth_axis_tlast, eth_axis_tvalid, eth_axis_tready = 1'b0;
  logic        arp_lookup_req = 1'b0;
  logic [31:0] arp_lookup_ip = '0;
  logic        arp_lookup_done, arp_lookup_valid;
  logic [47:0] arp_lookup_mac;

  int checks = 0;
  int errors = 0;
  logic [7:0]  frm[$];
  logic [7:0]  exp_q[$];
  logic [47:0] exp_dst_q[$];

  arp_engine dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .eth_req          (eth_req),
    .eth_ack          (eth_ack),
    .eth_dst_mac      (eth_dst_mac),
    .eth_src_mac      (eth_src_mac),
    .eth_ethertype    (eth_ethertype),
    .eth_axis_tdata   (eth_axis_tdata),
    .eth_axis_tlast   (eth_axis_tlast),
    .eth_axis_tvalid  (eth_axis_tvalid),
    .eth_axis_tready  (eth_axis_tready),
    .arp_lookup_req   (arp_lookup_req),
    .arp_lookup_ip    (arp_lookup_ip),
    .arp_lookup_done  (arp_lookup_done),
    .arp_lookup_valid (arp_lookup_valid),
    .arp_lookup_mac   (arp_lookup_mac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mk_arp(input logic [15:0] ptype, input logic [15:0] oper, input logic [47:0] sha,
                        input logic [31:0] spa, input logic [47:0] tha, input logic [31:0] tpa);
    logic [223:0] v;
    v = {16'h0001, ptype, 8'h06, 8'h04, oper, sha, spa, tha, tpa};
    frm.delete();
    for (int i = 0; i < 28; i++) frm.push_back(v[223-8*i -: 8]);
  endtask

  task automatic push_exp(input logic [47:0] dst, input logic [15:0] oper,
                          input logic [47:0] tha, input logic [31:0] tpa);
    logic [223:0] v;
    v = {16'h0001, 16'h0800, 8'h06, 8'h04, oper, LMac, LIp, tha, tpa};
    exp_dst_q.push_back(dst);
    for (int i = 0; i < 28; i++) exp_q.push_back(v[223-8*i -: 8]);
  endtask

  // Called at a negedge; returns at the negedge after the last byte is accepted.
  task automatic drive_frame();
    int w;
    for (int i = 0; i < frm.size(); i++) begin
      s_axis_tdata  = frm[i];
      s_axis_tlast  = (i == frm.size() - 1);
      s_axis_tvalid = 1'b1;
      w = 0;
      while (!s_axis_tready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        chk("rx_ready_timeout", s_axis_tready, 1);
        break;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic collect_frame(input bit toggle, input bit is_reply);
    int w, n, k;
    logic [7:0] e;
    w = 0;
    while (!eth_req && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("eth_req", eth_req, 1);
    chk("eth_dst", eth_dst_mac, exp_dst_q.pop_front());
    chk("eth_src", eth_src_mac, LMac);
    chk("eth_type", eth_ethertype, 16'h0806);
    eth_ack = 1'b1;
    @(negedge clk);
    eth_ack = 1'b0;
    chk("eth_req_drop", eth_req, 0);
    n = 0;
    k = 0;
    w = 0;
    while (n < 28 && w < 300) begin
      eth_axis_tready = toggle ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      k++;
      if (is_reply) chk("rx_blocked", s_axis_tready, 0);
      if (n > 0) chk("tx_valid_held", eth_axis_tvalid, 1);
      if (eth_axis_tvalid && eth_axis_tready) begin
        e = exp_q.pop_front();
        chk($sformatf("tx_byte%0d", n), eth_axis_tdata, e);
        chk($sformatf("tx_last%0d", n), eth_axis_tlast, (n == 27));
        n++;
      end
      @(negedge clk);
      w++;
    end
    eth_axis_tready = 1'b0;
    chk("tx_count", n, 28);
    chk("tx_idle", eth_axis_tvalid, 0);
    if (is_reply) chk("rx_ready_after", s_axis_tready, 1);
  endtask

  task automatic lookup(input logic [31:0] ip, input bit hit, input logic [47:0] mac);
    arp_lookup_req = 1'b1;
    arp_lookup_ip  = ip;
    @(negedge clk);
    arp_lookup_req = 1'b0;
    arp_lookup_ip  = '0;
    chk("lk_done", arp_lookup_done, 1);
    chk("lk_valid", arp_lookup_valid, hit);
    if (hit) chk("lk_mac", arp_lookup_mac, mac);
    else push_exp(48'hffffffffffff, 16'h0001, 48'h0, ip);
    @(negedge clk);
    chk("lk_done_pulse", arp_lookup_done, 0);
  endtask

  task automatic no_tx();
    repeat (10) @(negedge clk);
    chk("no_eth_req", eth_req, 0);
    chk("rx_ready_idle", s_axis_tready, 1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_rx_ready", s_axis_tready, 0);
    chk("rst_eth_req", eth_req, 0);
    chk("rst_tx_valid", eth_axis_tvalid, 0);
    chk("rst_lk_done", arp_lookup_done, 0);
    chk("rst_dst", eth_dst_mac, 0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rx_ready_up", s_axis_tready, 1);

    // 1: request for local IP -> reply
    mk_arp(16'h0800, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80601, 48'h0, LIp);
    push_exp(48'h0a0b0c0d0e0f, 16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80601);
    drive_frame();
    chk("rx_ready_low_after_tlast", s_axis_tready, 0);
    collect_frame(1'b0, 1'b1);

    // 2: request for another IP -> learn only, then hit
    mk_arp(16'h0800, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80601, 48'h0, 32'hc0a80609);
    drive_frame();
    no_tx();
    lookup(32'hc0a80601, 1'b1, 48'h0a0b0c0d0e0f);

    // 3: miss -> broadcast request
    lookup(32'hc0a80663, 1'b0, 48'h0);
    collect_frame(1'b0, 1'b0);

    // 4: malformed frames are dropped without learning
    mk_arp(16'h86dd, 16'd1, 48'h111213141516, 32'hc0a80611, 48'h0, LIp);
    drive_frame();
    no_tx();
    lookup(32'hc0a80611, 1'b0, 48'h0);
    collect_frame(1'b0, 1'b0);
    mk_arp(16'h0800, 16'd1, 48'h121314151617, 32'hc0a80612, 48'h0, LIp);
    while (frm.size() > 20) void'(frm.pop_back());
    drive_frame();
    no_tx();
    lookup(32'hc0a80612, 1'b0, 48'h0);
    collect_frame(1'b0, 1'b0);
    // padded 46-byte frame, reply drained with tready toggling 1-0-0-1
    mk_arp(16'h0800, 16'd1, 48'h2a2b2c2d2e2f, 32'hc0a80620, 48'h0, LIp);
    repeat (18) frm.push_back(8'h00);
    push_exp(48'h2a2b2c2d2e2f, 16'h0002, 48'h2a2b2c2d2e2f, 32'hc0a80620);
    drive_frame();
    collect_frame(1'b1, 1'b1);
    lookup(32'hc0a80620, 1'b1, 48'h2a2b2c2d2e2f);

    // 6: eviction and in-place update on a clean cache
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mk_arp(16'h0800, 16'd2, 48'h00aa00bb0000 + 48'(i), 32'hc0a80631 + 32'(i), LMac, LIp);
      drive_frame();
    end
    no_tx();
    lookup(32'hc0a80631, 1'b0, 48'h0);
    collect_frame(1'b0, 1'b0);
    lookup(32'hc0a80635, 1'b1, 48'h00aa00bb0004);
    lookup(32'hc0a80632, 1'b1, 48'h00aa00bb0001);
    mk_arp(16'h0800, 16'd2, 48'hdeadbeef0033, 32'hc0a80633, LMac, LIp);
    drive_frame();
    no_tx();
    lookup(32'hc0a80633, 1'b1, 48'hdeadbeef0033);

    // reset in the middle of a reply
    mk_arp(16'h0800, 16'd1, 48'h5a5b5c5d5e5f, 32'hc0a80640, 48'h0, LIp);
    drive_frame();
    repeat (4) @(negedge clk);
    chk("mid_eth_req", eth_req, 1);
    eth_ack = 1'b1;
    @(negedge clk);
    eth_ack = 1'b0;
    eth_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_tx_valid", eth_axis_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("abort_tx_valid", eth_axis_tvalid, 0);
    chk("abort_eth_req", eth_req, 0);
    chk("abort_rx_ready", s_axis_tready, 0);
    eth_axis_tready = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_abort_req", eth_req, 0);
    chk("post_abort_ready", s_axis_tready, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
